// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if
// Groups the PLL-facing and system-facing signals of the reset sequencer.
//   pll_lock   : raw PLL LOCK output (asynchronous to the sequencer clock)
//   pll_resetb : active-low reset to the PLL
//   sys_rst_n  : active-low reset for the system domain
//   state      : current sequencer state, for debug/LED
//   relock_cnt : saturating count of lock losses and lock timeouts
// The master modport is the sequencer side. The slave modport is the PLL/system side.
interface pll_reset_seq_if;
    logic       pll_lock;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic [1:0] state;
    logic [7:0] relock_cnt;

    modport master (
        input  pll_lock,
        output pll_resetb,
        output sys_rst_n,
        output state,
        output relock_cnt
    );

    modport slave (
        output pll_lock,
        input  pll_resetb,
        input  sys_rst_n,
        input  state,
        input  relock_cnt
    );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
// Power-up and lock-supervision sequencer for the board PLL. It pulses the PLL
// reset and waits for lock. It releases the system reset only after lock has been
// stable for LOCK_STABLE_CYCLES cycles. If lock is lost, it re-asserts the system
// reset and restarts the PLL. It runs from the reference clock only.
//   clk   : reference clock (the only clock)
//   rst_n : asynchronous active-low reset
//   bus   : pll_reset_seq_if.master (pll_lock in; pll_resetb, sys_rst_n,
//           state, relock_cnt out)
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    pll_reset_seq_if.master   bus
);

    localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       relock_q;
    logic             relock_inc;
    logic             pll_resetb_q;
    logic             sys_rst_n_q;
    logic             lock_meta, lock_s;

    // The two-flop synchronizer brings the asynchronous lock into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state logic. In STABLE a lock drop wins over the terminal count.
    // In WAIT_LOCK an arriving lock wins over the timeout.
    always_comb begin
        state_nxt  = state_q;
        relock_inc = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_nxt  = PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s)                    state_nxt = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt  = PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            default: state_nxt = PLL_RST;
        endcase
    end

    // The shared counter restarts on every state change. It holds in RUN, where
    // nothing is timed, so it can never wrap.
    always_comb begin
        cnt_nxt = cnt_q;
        if (state_nxt != state_q)
            cnt_nxt = '0;
        else if (state_q != RUN)
            cnt_nxt = cnt_q + CNT_W'(1);
    end

    // The outputs are decoded from the next state and registered. They move on the
    // same edge as the state, and sys_rst_n can never glitch high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            relock_q     <= 8'd0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            pll_resetb_q <= (state_nxt != PLL_RST);
            sys_rst_n_q  <= (state_nxt == RUN);
            if (relock_inc && (relock_q != 8'hFF))
                relock_q <= relock_q + 8'd1;
        end
    end

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.state      = state_q;
    assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
// Directed bench for pll_reset_seq with PLL_RST_CYCLES=4, LOCK_TIMEOUT=32 and
// LOCK_STABLE_CYCLES=8. Edges are counted from the first rising edge after
// rst_n is released. The expected values are worked out by hand from those
// edge counts.
module tb_pll_reset_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (32),
        .LOCK_STABLE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // 10-unit reference clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Drive pll_lock for the coming edge, then sample 1 unit after that edge.
    task automatic applyStimulus(input logic lock_value);
        bus.pll_lock = lock_value;
        @(posedge clk);
        #1;
    endtask

    // Pulse rst_n between edges. It is called 1 unit after an edge.
    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;

        // Reset values before any clock edge.
        #3;
        checkOutput("rst_state",  32'(bus.state), 0);
        checkOutput("rst_resetb", 32'(bus.pll_resetb), 0);
        checkOutput("rst_sys",    32'(bus.sys_rst_n), 0);
        checkOutput("rst_relock", 32'(bus.relock_cnt), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Cold start: lock rises after edge 10; release comes 11 edges later, at edge 21.
        for (int i = 1; i <= 21; i++) begin
            applyStimulus(i > 10);
            checkOutput("cold_resetb", 32'(bus.pll_resetb), (i >= 4) ? 1 : 0);
            checkOutput("cold_sys",    32'(bus.sys_rst_n), (i == 21) ? 1 : 0);
            checkOutput("cold_state",  32'(bus.state),
                        (i < 4) ? 0 : (i <= 12) ? 1 : (i <= 20) ? 2 : 3);
        end
        checkOutput("cold_relock", 32'(bus.relock_cnt), 0);

        // Lock loss in RUN: the drop shows on edge 3, then the sequence repeats.
        for (int j = 1; j <= 16; j++) begin
            applyStimulus(j > 3);
            checkOutput("loss_sys",    32'(bus.sys_rst_n), (j < 3 || j == 16) ? 1 : 0);
            checkOutput("loss_resetb", 32'(bus.pll_resetb), (j >= 3 && j <= 6) ? 0 : 1);
            checkOutput("loss_state",  32'(bus.state),
                        (j < 3) ? 3 : (j <= 6) ? 0 : (j == 7) ? 1 : (j <= 15) ? 2 : 3);
            checkOutput("loss_relock", 32'(bus.relock_cnt), (j < 3) ? 0 : 1);
        end

        // Async reset mid-RUN: the outputs clear with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_state",  32'(bus.state), 0);
        checkOutput("async_resetb", 32'(bus.pll_resetb), 0);
        checkOutput("async_sys",    32'(bus.sys_rst_n), 0);
        checkOutput("async_relock", 32'(bus.relock_cnt), 0);
        #1 rst_n = 1'b1;

        // Unstable lock: STABLE is entered at edge 5 and the drop is seen at count 5.
        // The retry is again held for the full 8 cycles.
        for (int i = 1; i <= 22; i++) begin
            applyStimulus(!(i >= 9 && i <= 11));
            checkOutput("unst_sys",   32'(bus.sys_rst_n), (i == 22) ? 1 : 0);
            checkOutput("unst_state", 32'(bus.state),
                        (i < 4) ? 0 : (i == 4) ? 1 : (i <= 10) ? 2 :
                        (i <= 13) ? 1 : (i <= 21) ? 2 : 3);
            checkOutput("unst_relock", 32'(bus.relock_cnt), 0);
        end

        // Terminal-count collision: lock_s drops exactly when the STABLE count is 7.
        pulseReset();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(i <= 10);
            checkOutput("tc_sys",   32'(bus.sys_rst_n), 0);
            checkOutput("tc_state", 32'(bus.state),
                        (i < 4) ? 0 : (i == 4) ? 1 : (i <= 12) ? 2 : 1);
        end
        checkOutput("tc_relock", 32'(bus.relock_cnt), 0);

        // Lock never arrives: the period is 36 edges, with pll_resetb low on edges 36k..36k+3.
        // relock_cnt saturates at 255.
        pulseReset();
        for (int i = 1; i <= 9216; i++) begin
            applyStimulus(1'b0);
            checkOutput("nolock_resetb", 32'(bus.pll_resetb), ((i % 36) <= 3) ? 0 : 1);
            checkOutput("nolock_relock", 32'(bus.relock_cnt),
                        ((i / 36) > 255) ? 255 : (i / 36));
            checkOutput("nolock_sys", 32'(bus.sys_rst_n), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Power-up and lock-supervision sequencer for the board PLL. Drives the PLL's active-low reset, watches the asynchronous PLL lock output, and releases the system reset only after lock has been stable for a programmable interval. Loss of lock re-asserts system reset and restarts the PLL. Runs on the 16 MHz reference clock, so it never depends on the clock it supervises.

## Interface
- `PLL_RST_CYCLES`, default 16: cycles `pll_resetb` is held low per PLL reset pulse; ≥1.
- `LOCK_TIMEOUT`, default 65536: max cycles in WAIT_LOCK before the PLL is reset again; ≥1.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock-high cycles required before release; ≥1.
- `clk`, input, 1: 16 MHz reference clock. This is the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset (button / power-on).
- `pll_lock`, input, 1: PLL LOCK output. Asynchronous to `clk`.
- `pll_resetb`, output, 1: to PLL RESETB. Active low. Registered.
- `sys_rst_n`, output, 1: active-low reset for the system domain. Registered.
- `state`, output, 2: current state encoding, for debug/LED.
- `relock_cnt`, output, 8: saturating count of lock losses in RUN plus lock timeouts.

## Operation
- `pll_lock` passes through a 2-flop synchronizer before use. Both flops reset to 0. The synchronized signal is `lock_s`.
- A single down-counter or up-counter `cnt` is shared by all states. It is cleared on every state entry.
  - Width is clog2 of the largest parameter, plus 1.
- States, with `state` encoding:
  - **PLL_RST (0)**
    - `pll_resetb`=0, `sys_rst_n`=0.
    - When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - **WAIT_LOCK (1)**
    - `pll_resetb`=1, `sys_rst_n`=0.
    - If `lock_s`=1, go to STABLE.
    - Otherwise, if `cnt`==LOCK_TIMEOUT-1, go to PLL_RST and increment `relock_cnt`.
  - **STABLE (2)**
    - `pll_resetb`=1, `sys_rst_n`=0.
    - If `lock_s`=0, go to WAIT_LOCK. The counter restarts and `relock_cnt` is unchanged.
    - Otherwise, if `cnt`==LOCK_STABLE_CYCLES-1, go to RUN.
  - **RUN (3)**
    - `pll_resetb`=1, `sys_rst_n`=1.
    - If `lock_s`=0, go to PLL_RST and increment `relock_cnt`.
- Outputs are registered decodes of the next state, so each output changes on the same edge as the state.
- `relock_cnt` saturates at 255 and never wraps. It is cleared only by `rst_n`.
- Simultaneous events:
  - In STABLE, a lock drop on the terminal count cycle takes priority: go to WAIT_LOCK, not RUN.
  - In WAIT_LOCK, lock rising on the timeout cycle takes priority: go to STABLE and do not increment `relock_cnt`.
- A glitch on `pll_lock` shorter than one `clk` period may be missed by the synchronizer. This is acceptable.

## Timing
- Reset values (`rst_n`=0), applied asynchronously:
  - `state`=PLL_RST
  - `pll_resetb`=0
  - `sys_rst_n`=0
  - `cnt`=0
  - `relock_cnt`=0
  - synchronizer flops = 0
- Assertion of `rst_n` mid-operation returns the block to PLL_RST immediately and drops `sys_rst_n` immediately, with no clock required.
- After `rst_n` deasserts, `pll_resetb` stays low for exactly PLL_RST_CYCLES rising edges.
- Lock-to-release latency: `pll_lock` rising reaches `lock_s` after 2 edges. Entry to STABLE takes 1 more edge, then LOCK_STABLE_CYCLES edges in STABLE. Total: `sys_rst_n` rises LOCK_STABLE_CYCLES+3 edges after `pll_lock` rises, provided lock stays high throughout.
- Lock-loss latency in RUN: `sys_rst_n` and `pll_resetb` fall 3 edges after `pll_lock` falls (2 synchronizer edges + 1 state edge).
- `sys_rst_n` never glitches high. It is 1 only while `state`==RUN.

## Test plan
Benches use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8.

- **Cold start.** Release `rst_n`; raise `pll_lock` 10 cycles later and hold it.
  - Required: `pll_resetb` low for exactly 4 cycles.
  - Required: `sys_rst_n` rises exactly 11 edges after `pll_lock` rises.
  - Required: `state` sequence 0→1→2→3; `relock_cnt`=0.
- **Lock never arrives.** Hold `pll_lock`=0.
  - Required: a 4-cycle `pll_resetb` low pulse every 36 cycles.
  - Required: `relock_cnt` increments on each timeout and saturates at 255 after 255 timeouts.
- **Unstable lock.** In STABLE, drop `pll_lock` for 3 cycles at count 5.
  - Required: return to WAIT_LOCK; `sys_rst_n` stays 0; `relock_cnt` unchanged.
  - Required: on the next stable lock, release takes the full 8 cycles again.
- **Lock loss in RUN.** Drop `pll_lock`.
  - Required: `sys_rst_n`=0 and `pll_resetb`=0 on the 3rd edge after the drop; `relock_cnt`=1.
  - Required: the full sequence then repeats.
- **Async reset mid-RUN.** Pulse `rst_n` low between clock edges.
  - Required: `sys_rst_n`, `pll_resetb`, `state` and `relock_cnt` go to their reset values before the next edge.
- **Terminal-count collision.** Drop `lock_s` exactly on STABLE count 7.
  - Required: next state is WAIT_LOCK; `sys_rst_n` never goes high.
